// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy fire scheduler.
package enemy_pkg;

    localparam int unsigned ID_WIDTH    = 4;
    localparam int unsigned COORD_WIDTH = 11;
    localparam int unsigned MAX_ENEMIES = 1 << ID_WIDTH;

    typedef logic [COORD_WIDTH-1:0] coord_t;
    typedef logic [ID_WIDTH-1:0]    enemy_id_t;

    typedef enum logic [1:0] {
        COOLDOWN = 2'd0,
        SCAN     = 2'd1,
        REQUEST  = 2'd2
    } fire_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/enemy_fireLfsr.sv
// 8-bit Fibonacci LFSR supplying cooldown jitter; advances only when enabled.
module enemy_fireLfsr
    import enemy_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr_q <= LFSR_SEED;
        end else if (enable) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/enemy_firescheduler.sv
// Picks the next live enemy round-robin, paces launches with a jittered frame cooldown,
// caps shots in flight and offers each launch to the spawner over fireReq/fireAck.
module enemy_firescheduler
    import enemy_pkg::*;
#(
    parameter int unsigned AMOUNT_OF_ENEMIES  = 2,
    parameter int unsigned ENEMY_WIDTH        = 20,
    parameter int unsigned ENEMY_HEIGHT       = 20,
    parameter int unsigned MAX_ACTIVE_SHOTS   = 3,
    parameter int unsigned FIRE_PERIOD_FRAMES = 60,
    parameter int unsigned JITTER_BITS        = 4
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                startOfFrame,
    input  logic                                pause,
    input  logic [AMOUNT_OF_ENEMIES-1:0]        enemyAlive,
    input  coord_t [AMOUNT_OF_ENEMIES-1:0]      enemiesTLX,
    input  coord_t [AMOUNT_OF_ENEMIES-1:0]      enemiesTLY,
    input  logic                                fireAck,
    input  logic                                shotRetired,
    output logic                                fireReq,
    output coord_t                              fireX,
    output coord_t                              fireY,
    output enemy_id_t                           fireEnemyId,
    output logic [3:0]                          activeShots
);

    localparam enemy_id_t  LAST_ID     = enemy_id_t'(AMOUNT_OF_ENEMIES - 1);
    localparam logic [7:0] JITTER_MASK = 8'((1 << JITTER_BITS) - 1);
    localparam logic [8:0] PERIOD      = 9'(FIRE_PERIOD_FRAMES);
    localparam logic [3:0] MAX_SHOTS   = 4'(MAX_ACTIVE_SHOTS);
    localparam logic [4:0] SCAN_LIMIT  = 5'(AMOUNT_OF_ENEMIES);
    localparam coord_t     HALF_W      = coord_t'(ENEMY_WIDTH / 2);
    localparam coord_t     FULL_H      = coord_t'(ENEMY_HEIGHT);

    fire_state_e state_q, state_d;
    logic [8:0]  cooldown_q, cooldown_d;
    enemy_id_t   rr_ptr_q, rr_ptr_d;
    logic [4:0]  scan_count_q, scan_count_d;
    logic        fire_req_q, fire_req_d;
    coord_t      fire_x_q, fire_x_d;
    coord_t      fire_y_q, fire_y_d;
    enemy_id_t   fire_id_q, fire_id_d;
    logic [3:0]  active_q, active_d;

    logic [7:0]  lfsr;
    logic        lfsr_en;
    logic [8:0]  reload;
    logic        accept;
    logic        retire;
    enemy_id_t   rr_next;
    enemy_id_t   id_next;

    // Pad the enemy tables to the full id range so any rrPtr value indexes safely.
    logic [MAX_ENEMIES-1:0]   alive_ext;
    coord_t [MAX_ENEMIES-1:0] tlx_ext;
    coord_t [MAX_ENEMIES-1:0] tly_ext;

    for (genvar g = 0; g < MAX_ENEMIES; g++) begin : g_ext
        if (g < AMOUNT_OF_ENEMIES) begin : g_live
            assign alive_ext[g] = enemyAlive[g];
            assign tlx_ext[g]   = enemiesTLX[g];
            assign tly_ext[g]   = enemiesTLY[g];
        end else begin : g_pad
            assign alive_ext[g] = 1'b0;
            assign tlx_ext[g]   = '0;
            assign tly_ext[g]   = '0;
        end
    end

    assign lfsr_en = startOfFrame & ~pause;

    enemy_fireLfsr u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .enable (lfsr_en),
        .lfsr   (lfsr)
    );

    assign reload  = PERIOD + {1'b0, lfsr & JITTER_MASK};
    assign accept  = (state_q == REQUEST) & fire_req_q & fireAck;
    assign retire  = shotRetired & (active_q != 4'd0);
    assign rr_next = (rr_ptr_q == LAST_ID) ? '0 : rr_ptr_q + enemy_id_t'(1);
    assign id_next = (fire_id_q == LAST_ID) ? '0 : fire_id_q + enemy_id_t'(1);

    always_comb begin
        state_d      = state_q;
        cooldown_d   = cooldown_q;
        rr_ptr_d     = rr_ptr_q;
        scan_count_d = scan_count_q;
        fire_req_d   = fire_req_q;
        fire_x_d     = fire_x_q;
        fire_y_d     = fire_y_q;
        fire_id_d    = fire_id_q;

        case (state_q)
            COOLDOWN: begin
                if (lfsr_en && cooldown_q != 9'd0) begin
                    cooldown_d = cooldown_q - 9'd1;
                end else if (cooldown_q == 9'd0 && !pause && active_q < MAX_SHOTS) begin
                    state_d      = SCAN;
                    scan_count_d = 5'd0;
                end
            end
            SCAN: begin
                if (pause) begin
                    // Cooldown stays at zero so the scan restarts once unpaused.
                    state_d = COOLDOWN;
                end else if (alive_ext[rr_ptr_q]) begin
                    fire_x_d   = tlx_ext[rr_ptr_q] + HALF_W;
                    fire_y_d   = tly_ext[rr_ptr_q] + FULL_H;
                    fire_id_d  = rr_ptr_q;
                    fire_req_d = 1'b1;
                    state_d    = REQUEST;
                end else begin
                    rr_ptr_d     = rr_next;
                    scan_count_d = scan_count_q + 5'd1;
                    if (scan_count_q + 5'd1 == SCAN_LIMIT) begin
                        cooldown_d = reload;
                        state_d    = COOLDOWN;
                    end
                end
            end
            REQUEST: begin
                if (accept) begin
                    fire_req_d = 1'b0;
                    rr_ptr_d   = id_next;
                    cooldown_d = reload;
                    state_d    = COOLDOWN;
                end
            end
            default: begin
                state_d = COOLDOWN;
            end
        endcase
    end

    always_comb begin
        active_d = active_q;
        if (accept && !retire && active_q < MAX_SHOTS) begin
            active_d = active_q + 4'd1;
        end else if (!accept && retire) begin
            active_d = active_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= COOLDOWN;
            cooldown_q   <= PERIOD;
            rr_ptr_q     <= '0;
            scan_count_q <= '0;
            fire_req_q   <= 1'b0;
            fire_x_q     <= '0;
            fire_y_q     <= '0;
            fire_id_q    <= '0;
            active_q     <= '0;
        end else begin
            state_q      <= state_d;
            cooldown_q   <= cooldown_d;
            rr_ptr_q     <= rr_ptr_d;
            scan_count_q <= scan_count_d;
            fire_req_q   <= fire_req_d;
            fire_x_q     <= fire_x_d;
            fire_y_q     <= fire_y_d;
            fire_id_q    <= fire_id_d;
            active_q     <= active_d;
        end
    end

    assign fireReq     = fire_req_q;
    assign fireX       = fire_x_q;
    assign fireY       = fire_y_q;
    assign fireEnemyId = fire_id_q;
    assign activeShots = active_q;

endmodule
